// File: rtl/rom_pkg.sv
// Shared definitions for the mask-ROM fetch controller.
// Latency: none (package only).
// Backpressure: not applicable.
// Contents: ROM geometry constants and the fetch FSM state encoding.
package rom_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_SIZE   = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rom_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO buffering ROM bytes for the output stream.
// Latency: a pushed word is visible at pop_data in the cycle after the push edge.
// Backpressure: push while full is accepted only together with a pop; pop while empty and
//   pushing passes the word straight through, so occupancy is unchanged in both cases.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears pointers and count)
//   push, push_data     write request and data
//   pop, pop_data       read request and head-of-queue data
//   full, empty, count  occupancy status
module rom_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  // Empty + push + pop: the incoming word is consumed in the same cycle.
  assign bypass   = empty && push && pop;
  assign do_push  = push && (!full || pop) && !bypass;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// ROM fetch initiator: reads `length` bytes from `base_addr` of the 32Kx8 mask ROM and streams them out.
// Latency: first rom_oen low 1 cycle after start is accepted; first m_valid READ_LAT+2 cycles after start.
// Backpressure: reads are issued only while FIFO free slots exceed reads in flight; m_data/m_valid hold until m_ready.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset (aborts any transfer, no done pulse)
//   start, base_addr, length   request pulse and its parameters (sampled on acceptance, ignored while busy)
//   busy, done                 busy from acceptance through the done cycle; done is a 1-cycle pulse
//   rom_addr, rom_oen, rom_data  registered ROM address / active-low read enable, ROM read data
//   m_data, m_valid, m_ready   valid/ready output byte stream
//   csum                       16-bit sum of streamed bytes, present only when ROM_FETCH_CSUM_EN is defined
module rom_fetch_ctrl
  import rom_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oen,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef ROM_FETCH_CSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [15:0]       remaining;
  logic [CNT_W-1:0]  inflight;
  logic [READ_LAT-1:0] tag;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [DATA_W-1:0] fifo_head;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] issue_addr;
  logic [15:0]       issue_len;
  logic [CNT_W:0]    credit;

  assign accept  = (state == IDLE) && start;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign push    = tag[READ_LAT-1];
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign pop     = m_valid && m_ready;
  // A slot freed by this cycle's pop counts, which keeps the stream bubble-free at full rate.
  assign credit  = DEPTH_C - {1'b0, fifo_count} + {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = addr_cnt;
    issue_len  = remaining;
    case (state)
      IDLE: begin
        if (accept) begin
          if (length == 16'd0) begin
            state_nxt = DONE;
          end else begin
            // FIFO is empty and nothing is in flight in IDLE, so the first read always has credit.
            issue      = 1'b1;
            issue_addr = base_addr;
            issue_len  = length;
            state_nxt  = (length == 16'd1) ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (credit > {1'b0, inflight}) begin
          issue = 1'b1;
          if (remaining == 16'd1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Finish on the edge that handshakes the final beat.
        if (inflight == '0 &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      inflight  <= '0;
      tag       <= '0;
      rom_addr  <= '0;
      rom_oen   <= 1'b1;
    end else begin
      state   <= state_nxt;
      rom_oen <= !issue;
      // Capture tag follows the issue cycle, so bus contents outside expected read slots are never pushed.
      tag[0]  <= !rom_oen;
      for (int i = 1; i < READ_LAT; i++) tag[i] <= tag[i-1];
      inflight <= inflight + {{(CNT_W-1){1'b0}}, issue} - {{(CNT_W-1){1'b0}}, push};
      if (issue) begin
        rom_addr  <= issue_addr;
        addr_cnt  <= issue_addr + ADDR_W'(1);
        remaining <= issue_len - 16'd1;
      end
    end
  end

`ifdef ROM_FETCH_CSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      csum <= '0;
    else if (accept) csum <= '0;
    else if (pop)    csum <= csum + 16'(fifo_head);
  end
`endif

  rom_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rom_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a 1-cycle registered ROM model.
// Covers basic fetch, backpressure, address wrap, zero length, mid-transfer reset and
// (with ROM_FETCH_CSUM_EN) the stream checksum.
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [14:0] rom_addr;
  logic        rom_oen;
  logic [7:0]  rom_data = 8'hEE;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
`ifdef ROM_FETCH_CSUM_EN
  logic [15:0] csum;
  logic [15:0] done_csum;
`endif

  always #5 clk = ~clk;

  rom_fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_oen   (rom_oen),
    .rom_data  (rom_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef ROM_FETCH_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // ROM model: registered read, garbage on the bus when not reading.
  logic [7:0] rom_mem [32768];
  always @(posedge clk) rom_data <= (!rom_oen) ? rom_mem[rom_addr] : 8'hEE;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int vld_first = -1;
  logic [7:0]  got[$];
  int          hs_cyc[$];
  logic [14:0] iss_addr[$];
  int          iss_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got.delete(); hs_cyc.delete(); iss_addr.delete(); iss_cyc.delete();
    done_cnt = 0; done_cyc = -1; vld_first = -1;
  endtask

  // Sample the settled cycle, then advance one clock.
  task automatic step();
    #1;
    if (m_valid && m_ready) begin got.push_back(m_data); hs_cyc.push_back(cyc); end
    if (!rom_oen) begin iss_addr.push_back(rom_addr); iss_cyc.push_back(cyc); end
    if (m_valid && vld_first < 0) vld_first = cyc;
    if (done) begin
      done_cnt++; done_cyc = cyc;
`ifdef ROM_FETCH_CSUM_EN
      done_csum = csum;
`endif
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic kick(input logic [14:0] b, input logic [15:0] l);
    clr();
    base_addr = b; length = l; start = 1'b1; t0 = cyc;
    step();
    start = 1'b0; base_addr = 15'h5555; length = 16'h7777;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    chk(tag, done_cnt, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_oen"}, rom_oen, 1);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
`ifdef ROM_FETCH_CSUM_EN
    chk({tag, "_csum"}, csum, 0);
`endif
  endtask

  initial begin
    logic [7:0]  exp3 [4];
    logic [14:0] adr3 [4];
    for (int i = 0; i < 32768; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
    rom_mem[0] = 8'h11; rom_mem[1] = 8'h22; rom_mem[2] = 8'h33; rom_mem[3] = 8'h44;
    for (int i = 0; i < 8; i++) rom_mem[16 + i] = 8'h40 + 8'(i);
    rom_mem[15'h7FFE] = 8'hA1; rom_mem[15'h7FFF] = 8'hB2;
    rom_mem[15'h0100] = 8'hC3; rom_mem[15'h0101] = 8'h5A;
    rom_mem[15'h0200] = 8'hFF; rom_mem[15'h0201] = 8'hFF; rom_mem[15'h0202] = 8'h02;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    steps(2);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    steps(2);

    // 1: four bytes at full rate
    m_ready = 1'b1;
    kick(15'h0000, 16'd4);
    chk("t1_busy", busy, 1);
    wait_done("t1_done_seen", 40);
    chk("t1_busy_after", busy, 0);
    steps(3);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, t0 + 7);
    chk("t1_n_issue", iss_addr.size(), 4);
    chk("t1_first_issue", iss_cyc[0], t0 + 1);
    chk("t1_last_issue", iss_cyc[3], t0 + 4);
    for (int i = 0; i < 4; i++) chk("t1_addr", iss_addr[i], i);
    chk("t1_first_valid", vld_first, t0 + 3);
    chk("t1_n_bytes", got.size(), 4);
    chk("t1_b0", got[0], 8'h11);
    chk("t1_b1", got[1], 8'h22);
    chk("t1_b2", got[2], 8'h33);
    chk("t1_b3", got[3], 8'h44);
    chk("t1_back2back", hs_cyc[3] - hs_cyc[0], 3);

    // 2: backpressure for 12 cycles, stray start while busy
    m_ready = 1'b0;
    kick(15'h0010, 16'd8);
    steps(5);
    start = 1'b1; base_addr = 15'h7000; length = 16'd5;
    step();
    start = 1'b0;
    chk("t2_hold_data_a", m_data, 8'h40);
    steps(5);
    chk("t2_issued_at_stall", iss_addr.size(), 4);
    chk("t2_hold_valid", m_valid, 1);
    chk("t2_hold_data_b", m_data, 8'h40);
    m_ready = 1'b1;
    wait_done("t2_done_seen", 80);
    steps(3);
    chk("t2_done_once", done_cnt, 1);
    chk("t2_n_issue", iss_addr.size(), 8);
    chk("t2_n_bytes", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_byte", got[i], 8'h40 + 8'(i));

    // 3: address wrap
    kick(15'h7FFE, 16'd4);
    wait_done("t3_done_seen", 40);
    adr3[0] = 15'h7FFE; adr3[1] = 15'h7FFF; adr3[2] = 15'h0000; adr3[3] = 15'h0001;
    exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'h11; exp3[3] = 8'h22;
    chk("t3_n_issue", iss_addr.size(), 4);
    chk("t3_n_bytes", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", iss_addr[i], adr3[i]);
      chk("t3_byte", got[i], exp3[i]);
    end

    // 4: zero length
    kick(15'h0123, 16'd0);
    chk("t4_done_next", done, 1);
    steps(5);
    chk("t4_done_cyc", done_cyc, t0 + 1);
    chk("t4_done_once", done_cnt, 1);
    chk("t4_no_issue", iss_addr.size(), 0);
    chk("t4_no_valid", vld_first, -1);

    // 5: reset mid-transfer, then a normal transfer
    kick(15'h0020, 16'd16);
    steps(3);
    rst_n = 1'b0;
    step();
    chk_reset_outputs("t5_rst");
    step();
    rst_n = 1'b1;
    clr();
    steps(10);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_stream", got.size(), 0);
    chk("t5_no_issue", iss_addr.size(), 0);
    kick(15'h0100, 16'd2);
    wait_done("t5_done_seen", 40);
    chk("t5_n_bytes", got.size(), 2);
    chk("t5_b0", got[0], 8'hC3);
    chk("t5_b1", got[1], 8'h5A);
    chk("t5_a1", iss_addr[1], 15'h0101);

`ifdef ROM_FETCH_CSUM_EN
    // 6: checksum with carry, then cleared by the next start
    kick(15'h0200, 16'd3);
    wait_done("t6_done_seen", 40);
    chk("t6_csum_at_done", done_csum, 16'h0200);
    chk("t6_csum_hold", csum, 16'h0200);
    kick(15'h0000, 16'd1);
    chk("t6_csum_clear", csum, 16'h0000);
    wait_done("t6_done2_seen", 40);
    chk("t6_csum2", done_csum, 16'h0011);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
